mccp_mem_arbiter: RTL and testbench

- Parametrised successor to the fixed 4-core videocard memory arbiter: grants one of CORE_NUM cores access to the shared data memory port.
- Grant policy is round-robin, with a per-core enable mask.
- Serves one access at a time through a request/response handshake and supports configurable synchronous-RAM read latency.
- Sits between the core array and the single-port video/data RAM inside the videocard top.

---
 rtl/mccp_mem_arbiter_if.sv | 44 ++++
 rtl/mccp_mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mccp_mem_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mccp_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mccp_mem_arbiter_if
//   Bundles the core-array side and the single-port RAM side of the shared
//   data-memory arbiter.
//
//   Core side    : core_en, request, wren_core, address_in_cores,
//                  data_in_cores (flattened, core i at [i*WIDTH +: WIDTH]),
//                  response (one-cycle done pulse), data_out_cores.
//   Memory side  : address, data_write, wren, data_read.
//   Status       : busy.
//
//   Modports
//     slave  : the arbiter's view (consumes requests, drives the RAM port).
//     master : the environment's view (core array plus RAM).
// ---------------------------------------------------------------------------
interface mccp_mem_arbiter_if #(
  parameter int WIDTH    = 32,
  parameter int CORE_NUM = 4
);
  logic [CORE_NUM-1:0]       core_en;
  logic [CORE_NUM-1:0]       request;
  logic [CORE_NUM-1:0]       wren_core;
  logic [CORE_NUM*WIDTH-1:0] address_in_cores;
  logic [CORE_NUM*WIDTH-1:0] data_in_cores;
  logic [CORE_NUM-1:0]       response;
  logic [CORE_NUM*WIDTH-1:0] data_out_cores;
  logic [WIDTH-1:0]          address;
  logic [WIDTH-1:0]          data_write;
  logic                      wren;
  logic [WIDTH-1:0]          data_read;
  logic                      busy;

  modport slave (
    input  core_en, request, wren_core, address_in_cores, data_in_cores,
           data_read,
    output response, data_out_cores, address, data_write, wren, busy
  );

  modport master (
    output core_en, request, wren_core, address_in_cores, data_in_cores,
           data_read,
    input  response, data_out_cores, address, data_write, wren, busy
  );
endinterface

// File: rtl/mccp_mem_arbiter.sv
// ---------------------------------------------------------------------------
// mccp_mem_arbiter
//   Grants one of CORE_NUM cores access to the shared single-port data RAM,
//   one access at a time, through a request/response handshake. All outputs
//   are registered.
//
//   Ports
//     clk     : single clock, all logic on posedge.
//     reset   : synchronous, active-high.
//     io_bus  : mccp_mem_arbiter_if.slave (core array + RAM port + busy).
//
//   Parameters
//     WIDTH    : data and address width.
//     CORE_NUM : number of requesting cores (>= 2).
//     IDX_W    : grant index width.
//     READ_LAT : cycles from address issue to valid data_read (>= 1).
//
//   Build option
//     ARB_FIXED_PRIORITY_EN : when defined, the lowest-index eligible core
//     always wins (core 0 can starve the others). Undefined (default):
//     round-robin starting after the last granted core.
//
//   Timing, request first seen in IDLE at cycle T:
//     ISSUE at T+1, write response at T+2, read response at T+2+READ_LAT.
// ---------------------------------------------------------------------------
module mccp_mem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int CORE_NUM = 4,
  parameter int IDX_W    = $clog2(CORE_NUM),
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  mccp_mem_arbiter_if.slave    io_bus
);

  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [IDX_W-1:0]          r_grant;
  logic [CNT_W-1:0]          r_cnt;
  logic [CORE_NUM-1:0]       r_response;
  logic [CORE_NUM*WIDTH-1:0] r_data_out;
  logic [WIDTH-1:0]          r_address;
  logic [WIDTH-1:0]          r_data_write;
  logic                      r_wren;
  logic                      r_busy;

  logic [CORE_NUM-1:0]       w_elig;
  logic [IDX_W-1:0]          w_win;
  logic                      w_found;

`ifndef ARB_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]          r_last_grant;
  logic [IDX_W-1:0]          w_idx;
`endif

  // Winner selection; only consulted in IDLE.
  // NOTE: every variable assigned in an always_comb gets a default first so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_elig  = io_bus.request & io_bus.core_en;
    w_found = 1'b0;
    w_win   = '0;
`ifdef ARB_FIXED_PRIORITY_EN
    // Descending scan so the lowest set index is the last one written.
    for (int k = CORE_NUM - 1; k >= 0; k--) begin
      if (w_elig[k]) begin
        w_win   = IDX_W'(k);
        w_found = 1'b1;
      end
    end
`else
    w_idx = '0;
    // Search upward from the core after the last grant, wrapping.
    for (int k = 0; k < CORE_NUM; k++) begin
      w_idx = IDX_W'((int'(r_last_grant) + 1 + k) % CORE_NUM);
      if (!w_found && w_elig[w_idx]) begin
        w_win   = w_idx;
        w_found = 1'b1;
      end
    end
`endif
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_found) w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = r_wren ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (r_cnt == '0) w_state_next = ST_RESP;
      ST_RESP:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // NOTE: r_data_out is a bank of per-core result registers, not a RAM, so
  // clearing it on reset is cheap and gives cores a defined initial value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant      <= '0;
      r_cnt        <= '0;
      r_response   <= '0;
      r_data_out   <= '0;
      r_address    <= '0;
      r_data_write <= '0;
      r_wren       <= 1'b0;
      r_busy       <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      r_last_grant <= IDX_W'(CORE_NUM - 1);
`endif
    end else begin
      // Pulses default low; address/data_write hold between accesses.
      r_response <= '0;
      r_wren     <= 1'b0;
      r_busy     <= (w_state_next != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          // The RAM-port registers double as the latched request, so later
          // changes on the core inputs cannot disturb the access.
          if (w_found) begin
            r_grant      <= w_win;
            r_address    <= io_bus.address_in_cores[w_win*WIDTH +: WIDTH];
            r_data_write <= io_bus.data_in_cores[w_win*WIDTH +: WIDTH];
            r_wren       <= io_bus.wren_core[w_win];
          end
        end
        ST_ISSUE: begin
`ifndef ARB_FIXED_PRIORITY_EN
          r_last_grant <= r_grant;
`endif
          r_cnt <= CNT_W'(READ_LAT - 1);
          if (r_wren) r_response[r_grant] <= 1'b1;
        end
        ST_WAIT: begin
          if (r_cnt == '0) begin
            r_data_out[r_grant*WIDTH +: WIDTH] <= io_bus.data_read;
            r_response[r_grant]                <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign io_bus.response       = r_response;
  assign io_bus.data_out_cores = r_data_out;
  assign io_bus.address        = r_address;
  assign io_bus.data_write     = r_data_write;
  assign io_bus.wren           = r_wren;
  assign io_bus.busy           = r_busy;

endmodule

// File: tb/tb_mccp_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mccp_mem_arbiter
//   Directed bench for mccp_mem_arbiter. bus1/u_dut1 use READ_LAT=1 with a
//   RAM whose data depends on the address; bus3/u_dut3 use READ_LAT=3 with a
//   RAM whose data encodes the current cycle, exposing the sample point.
//   Inputs change and outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mccp_mem_arbiter;
  localparam int WIDTH    = 32;
  localparam int CORE_NUM = 4;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] cyc   = '0;

  int n_checks = 0;
  int n_fail   = 0;

  int got_idx[16];
  int got_cyc[16];
  int got_n;

  mccp_mem_arbiter_if #(.WIDTH(WIDTH), .CORE_NUM(CORE_NUM)) bus1 ();
  mccp_mem_arbiter_if #(.WIDTH(WIDTH), .CORE_NUM(CORE_NUM)) bus3 ();

  mccp_mem_arbiter #(.WIDTH(WIDTH), .CORE_NUM(CORE_NUM), .READ_LAT(1)) u_dut1 (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus1)
  );

  mccp_mem_arbiter #(.WIDTH(WIDTH), .CORE_NUM(CORE_NUM), .READ_LAT(3)) u_dut3 (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEADBEEF : {16'hC0DE, a[15:0]};
  endfunction

  assign bus1.data_read = mem_f(bus1.address);
  assign bus3.data_read = {16'hBEEF, cyc[15:0]};

  function automatic int first_one(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus1.core_en = 4'hF; bus1.request = '0; bus1.wren_core = '0;
    bus1.address_in_cores = '0; bus1.data_in_cores = '0;
    bus3.core_en = 4'hF; bus3.request = '0; bus3.wren_core = '0;
    bus3.address_in_cores = '0; bus3.data_in_cores = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic set_lane1(input int i, input logic [31:0] a, input logic [31:0] d);
    bus1.address_in_cores[i*WIDTH +: WIDTH] = a;
    bus1.data_in_cores[i*WIDTH +: WIDTH]    = d;
  endtask

  // Runs until n response pulses appear on bus1 or the budget expires.
  // Returns at the sampling point of the last pulse's cycle.
  task automatic collect(input int n, input int budget);
    got_n = 0;
    for (int k = 0; k < 16; k++) begin got_idx[k] = -1; got_cyc[k] = -1; end
    for (int c = 0; c < budget && got_n < n; c++) begin
      tick();
      if (bus1.response != '0) begin
        check("resp_onehot", 32'($countones(bus1.response)), 32'd1);
        got_idx[got_n] = first_one(bus1.response);
        got_cyc[got_n] = c;
        got_n++;
      end
    end
    check("collect_count", got_n, n);
  endtask

  initial begin : main
    logic [31:0] c_issue;
    int          exp_ord[8];
    logic        seen;

    // ---------------- reset state ----------------
    clear_inputs();
    reset = 1'b1;
    tick();
    check("rst_response", bus1.response, 4'b0000);
    check("rst_wren", bus1.wren, 1'b0);
    check("rst_address", bus1.address, 32'h0);
    check("rst_data_write", bus1.data_write, 32'h0);
    check("rst_busy", bus1.busy, 1'b0);
    check("rst_data_out", bus1.data_out_cores, 128'h0);
    tick();
    reset = 1'b0;
    tick();

    // ---------------- core 2 read of 0x10 ----------------
    set_lane1(2, 32'h10, 32'h0);
    bus1.request = 4'b0100;
    tick();  // T+1 : ISSUE
    check("rd_address", bus1.address, 32'h10);
    check("rd_wren", bus1.wren, 1'b0);
    check("rd_busy", bus1.busy, 1'b1);
    tick();  // T+2 : WAIT
    check("rd_no_early_resp", bus1.response, 4'b0000);
    tick();  // T+3 : RESP
    check("rd_response", bus1.response, 4'b0100);
    check("rd_data_out", bus1.data_out_cores,
          {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    bus1.request = '0;
    tick();
    check("rd_idle_resp", bus1.response, 4'b0000);
    check("rd_idle_busy", bus1.busy, 1'b0);

    // ---------------- core 1 write of 0xA5A5A5A5 to 0x20 ----------------
    set_lane1(1, 32'h20, 32'hA5A5A5A5);
    bus1.request   = 4'b0010;
    bus1.wren_core = 4'b0010;
    tick();  // T+1 : ISSUE
    check("wr_wren_issue", bus1.wren, 1'b1);
    check("wr_data_write", bus1.data_write, 32'hA5A5A5A5);
    check("wr_address", bus1.address, 32'h20);
    check("wr_no_early_resp", bus1.response, 4'b0000);
    tick();  // T+2 : RESP
    check("wr_response", bus1.response, 4'b0010);
    check("wr_wren_low", bus1.wren, 1'b0);
    check("wr_data_out_kept", bus1.data_out_cores,
          {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
    check("wr_addr_hold", bus1.address, 32'h20);
    bus1.request = '0; bus1.wren_core = '0;
    tick();

`ifndef ARB_FIXED_PRIORITY_EN
    // ---------------- all four cores continuously ----------------
    do_reset();
    for (int i = 0; i < 4; i++) set_lane1(i, 32'h100 + 32'(4*i), 32'h0);
    bus1.request = 4'hF;
    collect(5, 60);
    bus1.request = '0;
    exp_ord = '{0, 1, 2, 3, 0, -1, -1, -1};
    for (int k = 0; k < 5; k++) check($sformatf("rr_order%0d", k), got_idx[k], exp_ord[k]);
    for (int k = 1; k < 5; k++) check($sformatf("rr_space%0d", k), got_cyc[k] - got_cyc[k-1], 4);
    check("rr_data_out", bus1.data_out_cores,
          {32'hC0DE010C, 32'hC0DE0108, 32'hC0DE0104, 32'hC0DE0100});
    tick();

    // ---------------- core_en = 1011 ----------------
    do_reset();
    for (int i = 0; i < 4; i++) set_lane1(i, 32'h100 + 32'(4*i), 32'h0);
    bus1.core_en = 4'b1011;
    bus1.request = 4'hF;
    collect(4, 60);
    exp_ord = '{0, 1, 3, 0, -1, -1, -1, -1};
    for (int k = 0; k < 4; k++) check($sformatf("en_order%0d", k), got_idx[k], exp_ord[k]);
    bus1.core_en = 4'hF;
    collect(3, 40);
    bus1.request = '0;
    exp_ord = '{1, 2, 3, -1, -1, -1, -1, -1};
    for (int k = 0; k < 3; k++) check($sformatf("en2_order%0d", k), got_idx[k], exp_ord[k]);
    tick();
    tick();

    // ---------------- disable/modify during an access ----------------
    set_lane1(1, 32'h30, 32'h0);
    bus1.request = 4'b0010;
    tick();  // ISSUE
    bus1.core_en = 4'b1101;
    set_lane1(1, 32'h99, 32'h0);
    check("mid_address", bus1.address, 32'h30);
    tick();
    check("mid_addr_latched", bus1.address, 32'h30);
    tick();  // RESP
    check("mid_response", bus1.response, 4'b0010);
    check("mid_data", bus1.data_out_cores[1*WIDTH +: WIDTH], 32'hC0DE0030);
    bus1.request = '0;
    bus1.core_en = 4'hF;
    tick();
`endif

    // ---------------- cores 0 and 3 continuously ----------------
    do_reset();
    set_lane1(0, 32'h200, 32'h0);
    set_lane1(3, 32'h20C, 32'h0);
    bus1.request = 4'b1001;
    collect(4, 60);
    bus1.request = '0;
`ifdef ARB_FIXED_PRIORITY_EN
    exp_ord = '{0, 0, 0, 0, -1, -1, -1, -1};
`else
    exp_ord = '{0, 3, 0, 3, -1, -1, -1, -1};
`endif
    for (int k = 0; k < 4; k++) check($sformatf("p03_order%0d", k), got_idx[k], exp_ord[k]);
    tick();

    // ---------------- READ_LAT = 3, core 0 read ----------------
    do_reset();
    tick();
    bus3.address_in_cores[0 +: WIDTH] = 32'h40;
    bus3.request = 4'b0001;
    tick();  // T+1 : ISSUE
    c_issue = cyc;
    check("l3_address", bus3.address, 32'h40);
    check("l3_wren", bus3.wren, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      check($sformatf("l3_no_resp_T%0d", k), bus3.response, 4'b0000);
    end
    tick();  // T+5 : RESP
    check("l3_response", bus3.response, 4'b0001);
    check("l3_data", bus3.data_out_cores[0 +: WIDTH],
          {16'hBEEF, 16'(c_issue + 32'd3)});
    bus3.request = '0;
    tick();

    // ---------------- reset while in WAIT ----------------
    bus3.address_in_cores[1*WIDTH +: WIDTH] = 32'h44;
    bus3.request = 4'b0010;
    tick();  // ISSUE
    check("rw_address", bus3.address, 32'h44);
    tick();  // WAIT
    check("rw_busy", bus3.busy, 1'b1);
    reset = 1'b1;
    bus3.request = '0;
    tick();
    check("rw_response", bus3.response, 4'b0000);
    check("rw_addr_zero", bus3.address, 32'h0);
    check("rw_busy_zero", bus3.busy, 1'b0);
    check("rw_wren_zero", bus3.wren, 1'b0);
    check("rw_data_out_zero", bus3.data_out_cores, 128'h0);
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (bus3.response != '0) seen = 1'b1;
    end
    check("rw_no_late_resp", seen, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
